cpu_sequencer: RTL

- Multi-cycle control FSM for the 16-bit CPU datapath.
- Fetches each instruction into IR and hands IR to the instruction decoder.
- Consumes the decoder's control outputs (LD, MW, MD, BS, OFF, HALT) and the ALU flags.
- Drives PC, memory handshakes and register-file write enable, so each instruction executes as fetch/decode/execute/memory/writeback.

---
 rtl/cpu_sequencer_if.sv | 46 ++++
 rtl/cpu_sequencer.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer_if.sv
// Bundle between the CPU sequencer and its memories, decoder, ALU flags and debug taps.
// STEP exists only when SINGLE_STEP_EN is defined.
interface cpu_sequencer_if #(
    parameter int PC_W = 8
);
    logic            RUN;
    logic            IMEM_REQ;
    logic            IMEM_RDY;
    logic [15:0]     INST_IN;
    logic [PC_W-1:0] PC;
    logic [15:0]     IR;
    logic            LD;
    logic            MW;
    logic            MD;
    logic [2:0]      BS;
    logic [5:0]      OFF;
    logic            HALT;
    logic            ZERO;
    logic            NEG;
    logic            DMEM_RE;
    logic            DMEM_WE;
    logic            DMEM_RDY;
    logic            RF_WE;
    logic [2:0]      STATE;
    logic            HALTED;
    logic [15:0]     RETIRED;
`ifdef SINGLE_STEP_EN
    logic            STEP;
`endif

    modport master (
        input  RUN, IMEM_RDY, INST_IN, LD, MW, MD, BS, OFF, HALT, ZERO, NEG, DMEM_RDY,
`ifdef SINGLE_STEP_EN
        input  STEP,
`endif
        output IMEM_REQ, PC, IR, DMEM_RE, DMEM_WE, RF_WE, STATE, HALTED, RETIRED
    );

    modport slave (
        output RUN, IMEM_RDY, INST_IN, LD, MW, MD, BS, OFF, HALT, ZERO, NEG, DMEM_RDY,
`ifdef SINGLE_STEP_EN
        output STEP,
`endif
        input  IMEM_REQ, PC, IR, DMEM_RE, DMEM_WE, RF_WE, STATE, HALTED, RETIRED
    );
endinterface

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/execute/memory/writeback controller for the 16-bit CPU.
// Optional macro SINGLE_STEP_EN: STEP=1 parks the FSM in IDLE after every retire.
module cpu_sequencer #(
    parameter int PC_W     = 8,
    parameter int RESET_PC = 0
) (
    input  logic CLK,
    input  logic RST_N,
    cpu_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    state_t          state_reg, state_next;
    logic [PC_W-1:0] pc_reg, pc_next;
    logic [15:0]     ir_reg, ir_next;
    logic [15:0]     retired_reg, retired_next;
    logic            ld_reg, ld_next;
    logic            mw_reg, mw_next;
    logic            md_reg, md_next;
    logic            retire;
    logic [7:0]      cond_tab;
    logic            taken;
    logic [PC_W-1:0] off_ext;
    state_t          retire_state;

    // Branch condition per BS code; codes 100-111 never branch.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_cond
            if (gi == 0) begin : g_eq
                assign cond_tab[gi] = bus.ZERO;
            end else if (gi == 1) begin : g_ne
                assign cond_tab[gi] = ~bus.ZERO;
            end else if (gi == 2) begin : g_gez
                assign cond_tab[gi] = ~bus.NEG;
            end else if (gi == 3) begin : g_ltz
                assign cond_tab[gi] = bus.NEG;
            end else begin : g_never
                assign cond_tab[gi] = 1'b0;
            end
        end
    endgenerate

    assign taken   = cond_tab[bus.BS];
    assign off_ext = PC_W'($signed(bus.OFF));

`ifdef SINGLE_STEP_EN
    assign retire_state = bus.STEP ? S_IDLE : S_FETCH;
`else
    assign retire_state = S_FETCH;
`endif

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_reg   <= S_IDLE;
            pc_reg      <= PC_W'(RESET_PC);
            ir_reg      <= 16'h0000;
            retired_reg <= 16'h0000;
            ld_reg      <= 1'b0;
            mw_reg      <= 1'b0;
            md_reg      <= 1'b0;
        end else begin
            state_reg   <= state_next;
            pc_reg      <= pc_next;
            ir_reg      <= ir_next;
            retired_reg <= retired_next;
            ld_reg      <= ld_next;
            mw_reg      <= mw_next;
            md_reg      <= md_next;
        end
    end

    // Decoder controls are captured in EXEC so MEM/WB strobes depend on state only.
    always_comb begin
        state_next   = state_reg;
        pc_next      = pc_reg;
        ir_next      = ir_reg;
        retired_next = retired_reg;
        ld_next      = ld_reg;
        mw_next      = mw_reg;
        md_next      = md_reg;
        retire       = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (bus.RUN) state_next = S_FETCH;
            end
            S_FETCH: begin
                if (bus.IMEM_RDY) begin
                    ir_next    = bus.INST_IN;
                    pc_next    = pc_reg + PC_W'(1);
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                state_next = bus.HALT ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                ld_next = bus.LD;
                mw_next = bus.MW;
                md_next = bus.MD;
                if (taken) pc_next = pc_reg + off_ext;
                if (bus.MW || bus.MD) state_next = S_MEM;
                else if (bus.LD)      state_next = S_WB;
                else                  retire     = 1'b1;
            end
            S_MEM: begin
                if (bus.DMEM_RDY) begin
                    if (ld_reg) state_next = S_WB;
                    else        retire     = 1'b1;
                end
            end
            S_WB: begin
                retire = 1'b1;
            end
            S_HALT: begin
                state_next = S_HALT;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
        if (retire) begin
            state_next   = retire_state;
            retired_next = retired_reg + 16'd1;
        end
    end

    assign bus.IMEM_REQ = (state_reg == S_FETCH);
    assign bus.DMEM_RE  = (state_reg == S_MEM) && md_reg;
    assign bus.DMEM_WE  = (state_reg == S_MEM) && mw_reg;
    assign bus.RF_WE    = (state_reg == S_WB);
    assign bus.HALTED   = (state_reg == S_HALT);
    assign bus.STATE    = state_reg;
    assign bus.PC       = pc_reg;
    assign bus.IR       = ir_reg;
    assign bus.RETIRED  = retired_reg;
endmodule
